// File: rtl/barrel_unshifter_pipe_pkg.sv
// Shared width defaults and rotate helpers for the barrel shifter pair
// (forward rotate-right shifter and the rotate-left unshifter).
package barrel_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_SHIFT_W = $clog2(DEF_WIDTH);

  // Rotations via a doubled word, so no fill bits can ever appear.
  function automatic logic [DEF_WIDTH-1:0] rotl(input logic [DEF_WIDTH-1:0]   x,
                                                input logic [DEF_SHIFT_W-1:0] n);
    logic [2*DEF_WIDTH-1:0] w_dbl;
    w_dbl = {x, x} << n;
    return w_dbl[2*DEF_WIDTH-1:DEF_WIDTH];
  endfunction

  function automatic logic [DEF_WIDTH-1:0] rotr(input logic [DEF_WIDTH-1:0]   x,
                                                input logic [DEF_SHIFT_W-1:0] n);
    logic [2*DEF_WIDTH-1:0] w_dbl;
    w_dbl = {x, x} >> n;
    return w_dbl[DEF_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/barrel_unshifter_pipe_stage.sv
// One pipeline stage of the rotate-left unit: conditionally rotates by 2^K
// on load and holds its word while the downstream stage cannot advance.
module rotl_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int K       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic [WIDTH-1:0]   i_data,
  input  logic [SHIFT_W-1:0] i_amt,
  input  logic               i_adv_down,
  output logic               o_adv,
  output logic               o_valid,
  output logic [WIDTH-1:0]   o_data,
  output logic [SHIFT_W-1:0] o_amt
);

  localparam int STEP = 1 << K;

  logic               r_valid;
  logic [WIDTH-1:0]   r_data;
  logic [SHIFT_W-1:0] r_amt;
  logic [WIDTH-1:0]   w_rot;

  assign w_rot = i_amt[K] ? {i_data[WIDTH-STEP-1:0], i_data[WIDTH-1:WIDTH-STEP]} : i_data;

  // An empty stage can always take a word; a full one only if it can pass its own on.
  assign o_adv = !r_valid || i_adv_down;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_amt   <= '0;
    end else if (o_adv) begin
      r_valid <= i_valid;
      r_data  <= w_rot;
      r_amt   <= i_amt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_amt   = r_amt;

endmodule

// File: rtl/barrel_unshifter_pipe.sv
// Pipelined rotate-left unit restoring words rotated right before transport.
// One registered stage per shift-amount bit, LSB first, valid/ready on both sides.
module barrel_unshifter_pipe
  import barrel_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [SHIFT_W-1:0] n_bits,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   d_out
);

  // The final stage's amount has no consumer once its rotation is applied.
  logic [SHIFT_W-1:0] w_last_amt_unused;

  genvar gi;
  generate
    for (gi = 0; gi < SHIFT_W; gi++) begin : g_stage
      logic               w_up_valid;
      logic [WIDTH-1:0]   w_up_data;
      logic [SHIFT_W-1:0] w_up_amt;
      logic               w_adv_down;
      logic               w_adv;
      logic               w_valid;
      logic [WIDTH-1:0]   w_data;
      logic [SHIFT_W-1:0] w_amt;

      if (gi == 0) begin : g_head
        assign w_up_valid = in_valid;
        assign w_up_data  = d_in;
        assign w_up_amt   = n_bits;
      end else begin : g_body
        assign w_up_valid = g_stage[gi-1].w_valid;
        assign w_up_data  = g_stage[gi-1].w_data;
        assign w_up_amt   = g_stage[gi-1].w_amt;
      end

      // Ready ripples backwards combinationally so a stall releases in one cycle.
      if (gi == SHIFT_W - 1) begin : g_tail
        assign w_adv_down = out_ready;
      end else begin : g_link
        assign w_adv_down = g_stage[gi+1].w_adv;
      end

      rotl_stage #(
        .WIDTH   (WIDTH),
        .SHIFT_W (SHIFT_W),
        .K       (gi)
      ) u_stage (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_valid    (w_up_valid),
        .i_data     (w_up_data),
        .i_amt      (w_up_amt),
        .i_adv_down (w_adv_down),
        .o_adv      (w_adv),
        .o_valid    (w_valid),
        .o_data     (w_data),
        .o_amt      (w_amt)
      );
    end
  endgenerate

  assign in_ready          = g_stage[0].w_adv;
  assign out_valid         = g_stage[SHIFT_W-1].w_valid;
  assign d_out             = g_stage[SHIFT_W-1].w_data;
  assign w_last_amt_unused = g_stage[SHIFT_W-1].w_amt;

endmodule

// File: tb/tb_barrel_unshifter_pipe.sv
// Directed scoreboard bench for barrel_unshifter_pipe (WIDTH=8).
`timescale 1ns/1ps
module tb_barrel_unshifter_pipe;
  import barrel_pkg::*;

  localparam int W  = DEF_WIDTH;
  localparam int SW = DEF_SHIFT_W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  d_in;
  logic [SW-1:0] n_bits;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  d_out;

  logic [W-1:0]  cur_exp;
  logic [W-1:0]  sb[$];
  int            checks = 0;
  int            failures = 0;
  int            emitted = 0;
  int            cyc = 0;
  int            last_emit = 0;
  int            gap_viol = 0;
  bit            rt_mode = 1'b0;
  bit            have_last = 1'b0;
  bit            held = 1'b0;
  logic [W-1:0]  held_val = '0;

  always #5 clk = ~clk;

  barrel_unshifter_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .n_bits    (n_bits),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: transfers are decided at the next rising edge, sampled here mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rt_mode) have_last <= 1'b0;
    if (rst_n === 1'b1) begin
      if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(cur_exp);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        emitted <= emitted + 1;
        chk("out_has_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("d_out", d_out, sb.pop_front());
        if (rt_mode) begin
          if (have_last && (cyc - last_emit) != 1) gap_viol <= gap_viol + 1;
          have_last <= 1'b1;
          last_emit <= cyc;
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
        if (held) chk("stall_hold", d_out, held_val);
        held     <= 1'b1;
        held_val <= d_out;
      end else begin
        held <= 1'b0;
      end
    end else begin
      held <= 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [SW-1:0] n,
                      input logic [W-1:0] e, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    in_valid = 1'b1; d_in = d; n_bits = n; cur_exp = e;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      waits++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 1);
  endtask

  task automatic wait_drain(input string tag);
    int i;
    i = 0;
    while (i < 100 && (sb.size() != 0 || out_valid === 1'b1)) begin
      @(negedge clk);
      i++;
    end
    @(posedge clk); #1;
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, lat, e0, stalls;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    d_in = '0; n_bits = '0; cur_exp = '0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d_out", d_out, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word and its latency
    in_valid = 1'b1; d_in = 8'hB1; n_bits = 3'd3; cur_exp = 8'h8D;
    @(negedge clk);
    chk("single_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20 && out_valid !== 1'b1) begin
      @(negedge clk);
      lat++;
    end
    chk("single_latency", lat, 3);
    chk("single_d_out", d_out, 8'h8D);
    wait_drain("drain_single");

    // Boundary amounts
    send(8'h5A, 3'd0, 8'h5A, w);
    send(8'h01, 3'd7, 8'h80, w);
    send(8'h3C, 3'd4, 8'hC3, w);
    wait_drain("drain_boundary");

    // Round trip through the forward rotate, back-to-back
    rt_mode = 1'b1; e0 = emitted; stalls = 0; gap_viol = 0;
    for (int n = 0; n < 8; n++) begin
      for (int x = 0; x < 256; x++) begin
        send(rotr(W'(x), SW'(n)), SW'(n), W'(x), w);
        stalls += w - 1;
      end
    end
    wait_drain("drain_roundtrip");
    rt_mode = 1'b0;
    chk("rt_count", emitted - e0, 2048);
    chk("rt_in_ready_stalls", stalls, 0);
    chk("rt_output_gaps", gap_viol, 0);

    // Backpressure: three stages fill, fourth word waits
    out_ready = 1'b0; e0 = emitted;
    send(8'h11, 3'd1, 8'h22, w);
    send(8'h22, 3'd1, 8'h44, w);
    send(8'h33, 3'd1, 8'h66, w);
    in_valid = 1'b1; d_in = 8'h44; n_bits = 3'd1; cur_exp = 8'h88;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_d_out_head", d_out, 8'h22);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drain("drain_bp");
    chk("bp_count", emitted - e0, 4);

    // Reset with two words in flight
    out_ready = 1'b0;
    send(8'hA5, 3'd2, 8'h96, w);
    send(8'h0F, 3'd1, 8'h1E, w);
    @(posedge clk); #1;
    chk("rf_pre_out_valid", out_valid, 1);
    chk("rf_pre_d_out", d_out, 8'h96);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_async_out_valid", out_valid, 0);
    chk("rf_async_d_out", d_out, 0);
    chk("rf_async_in_ready", in_ready, 1);
    sb.delete();
    e0 = emitted;
    d_in = 'x; n_bits = 'x;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("rf_no_stale", out_valid, 0);
      chk("rf_in_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    chk("rf_emits", emitted - e0, 0);
    send(8'hC3, 3'd5, 8'h78, w);
    wait_drain("drain_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
